// File: rtl/kpn_fifo_reader.sv
// Purpose : consumer endpoint of a KPN channel FIFO; pops one token at a time and
//           presents it downstream on a valid/ready handshake.
// Latency : RD_LATENCY=1 -> token on out_valid 3 cycles after fifo_empty falls in IDLE;
//           steady state one token per 3 cycles with out_ready held high.
// Backpres: at most one token in flight; no read strobe is issued while a token
//           waits in HOLD, so a stalled consumer simply leaves tokens in the FIFO.
//
// Ports:
//   clk, reset           rising-edge clock, synchronous active-high reset
//   fifo_empty, fifo_rd  channel FIFO empty flag / one-cycle read strobe
//   fifo_data            channel FIFO read data, valid RD_LATENCY cycles after fifo_rd
//   out_data, out_valid  token presented downstream
//   out_ready            downstream accepts the token this cycle
//   tokens_read          delivered-token counter (only with KPN_READER_COUNT_EN
//                        defined; otherwise tied to zero and no flops exist)
//
// Parameters: BITS_NUMBER token width, COUNT_BITS counter width,
//             RD_LATENCY read latency of the FIFO (legal range 1..3).
// Optional feature macro: KPN_READER_COUNT_EN

module kpn_fifo_reader #(
  parameter int BITS_NUMBER = 16,
  parameter int COUNT_BITS  = 16,
  parameter int RD_LATENCY  = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   fifo_empty,
  output logic                   fifo_rd,
  input  logic [BITS_NUMBER-1:0] fifo_data,
  output logic [BITS_NUMBER-1:0] out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [COUNT_BITS-1:0]  tokens_read
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } state_t;

  // Extra WAIT cycles beyond the first; 2 bits cover RD_LATENCY up to 3.
  localparam logic [1:0] WAIT_INIT = 2'(RD_LATENCY - 1);

  state_t     state;
  state_t     state_nxt;
  logic [1:0] wait_cnt;
  logic [1:0] wait_cnt_nxt;
  logic       capture;
  logic       handshake;

  // out_valid is high exactly while in HOLD, so this is the delivery event.
  assign handshake = out_valid & out_ready;

  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    capture      = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          state_nxt = REQ;
        end
      end
      REQ: begin
        // The strobe is already committed; empty is not looked at again here.
        wait_cnt_nxt = WAIT_INIT;
        state_nxt    = WAIT;
      end
      WAIT: begin
        if (wait_cnt != 2'd0) begin
          wait_cnt_nxt = wait_cnt - 2'd1;
        end else begin
          capture   = 1'b1;
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (handshake) begin
          state_nxt = fifo_empty ? IDLE : REQ;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // fifo_rd and out_valid are decoded from the next state so that they are
  // registered yet line up exactly with the REQ and HOLD cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      wait_cnt  <= 2'd0;
      fifo_rd   <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      state     <= state_nxt;
      wait_cnt  <= wait_cnt_nxt;
      fifo_rd   <= (state_nxt == REQ);
      out_valid <= (state_nxt == HOLD);
      if (capture) begin
        out_data <= fifo_data;
      end
    end
  end

`ifdef KPN_READER_COUNT_EN
  logic [COUNT_BITS-1:0] tok_cnt;

  // Wraps naturally modulo 2**COUNT_BITS.
  always_ff @(posedge clk) begin
    if (reset) begin
      tok_cnt <= '0;
    end else if (handshake) begin
      tok_cnt <= tok_cnt + COUNT_BITS'(1);
    end
  end

  assign tokens_read = tok_cnt;
`else
  assign tokens_read = '0;
`endif

endmodule

// File: tb/tb_kpn_fifo_reader.sv
// Purpose : directed self-checking bench for kpn_fifo_reader; three instances
//           cover default parameters, RD_LATENCY=3 and COUNT_BITS=4.
// Latency : n/a (bench).
// Backpres: out_ready is driven by the stimulus to stall and release delivery.

module tb_kpn_fifo_reader;

`ifdef KPN_READER_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;

  always #5 clk = ~clk;

  // ---------------- main instance: defaults (RD_LATENCY=1, COUNT_BITS=16)
  logic        fifo_empty;
  logic        fifo_rd;
  logic [15:0] fifo_data = 16'hDEAD;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] tokens_read;

  kpn_fifo_reader dut (
    .clk(clk), .reset(reset), .fifo_empty(fifo_empty), .fifo_rd(fifo_rd),
    .fifo_data(fifo_data), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .tokens_read(tokens_read)
  );

  // ---------------- RD_LATENCY=3 instance, FIFO pins driven directly
  logic        fifo_empty3 = 1'b1;
  logic        fifo_rd3;
  logic [15:0] fifo_data3 = 16'h0000;
  logic [15:0] out_data3;
  logic        out_valid3;
  logic        out_ready3 = 1'b1;
  logic [15:0] tokens_read3;

  kpn_fifo_reader #(.RD_LATENCY(3)) dut3 (
    .clk(clk), .reset(reset), .fifo_empty(fifo_empty3), .fifo_rd(fifo_rd3),
    .fifo_data(fifo_data3), .out_data(out_data3), .out_valid(out_valid3),
    .out_ready(out_ready3), .tokens_read(tokens_read3)
  );

  // ---------------- COUNT_BITS=4 instance
  logic        fifo_empty4;
  logic        fifo_rd4;
  logic [15:0] fifo_data4 = 16'hDEAD;
  logic [15:0] out_data4;
  logic        out_valid4;
  logic        out_ready4 = 1'b1;
  logic [3:0]  tokens_read4;

  kpn_fifo_reader #(.COUNT_BITS(4)) dut4 (
    .clk(clk), .reset(reset), .fifo_empty(fifo_empty4), .fifo_rd(fifo_rd4),
    .fifo_data(fifo_data4), .out_data(out_data4), .out_valid(out_valid4),
    .out_ready(out_ready4), .tokens_read(tokens_read4)
  );

  // ---------------- FIFO models (latency 1) and monitors
  logic [15:0] mem  [0:63];
  logic [15:0] mem4 [0:31];
  int wr_idx = 0, rd_idx = 0, wr4 = 0, rd4 = 0;
  int cyc = 0, rd_cnt = 0, rx_cnt = 0, rd3_cnt = 0, rx4_cnt = 0, tr_bad4 = 0;
  int rd_cyc [0:63];
  logic [15:0] rx  [0:63];
  logic [15:0] rx4 [0:31];
  logic [3:0]  exp_tr4 = 4'd0;

  assign fifo_empty  = (rd_idx == wr_idx);
  assign fifo_empty4 = (rd4 == wr4);

  always @(posedge clk) begin
    cyc <= cyc + 1;
    // Non-read cycles present garbage so a mistimed capture is visible.
    if (fifo_rd && rd_idx != wr_idx) begin
      fifo_data <= mem[rd_idx];
      rd_idx    <= rd_idx + 1;
    end else begin
      fifo_data <= 16'hDEAD;
    end
    if (fifo_rd) begin
      rd_cyc[rd_cnt] <= cyc;
      rd_cnt         <= rd_cnt + 1;
    end
    if (!reset && out_valid && out_ready) begin
      rx[rx_cnt] <= out_data;
      rx_cnt     <= rx_cnt + 1;
    end
    if (fifo_rd3) rd3_cnt <= rd3_cnt + 1;

    if (fifo_rd4 && rd4 != wr4) begin
      fifo_data4 <= mem4[rd4];
      rd4        <= rd4 + 1;
    end else begin
      fifo_data4 <= 16'hBAD0;
    end
    if (!reset && out_valid4 && out_ready4) begin
      rx4[rx4_cnt] <= out_data4;
      rx4_cnt      <= rx4_cnt + 1;
    end
    // Reference counter for dut4: wraps at 16, or stays zero without the feature.
    if (cyc > 2 && tokens_read4 != exp_tr4) tr_bad4 <= tr_bad4 + 1;
    if (reset) exp_tr4 <= 4'd0;
    else if (out_valid4 && out_ready4 && CNT_EN) exp_tr4 <= exp_tr4 + 4'd1;
  end

  // ---------------- checking
  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push_main(input logic [15:0] d);
    mem[wr_idx] = d;
    wr_idx = wr_idx + 1;
  endtask

  task automatic push4(input logic [15:0] d);
    mem4[wr4] = d;
    wr4 = wr4 + 1;
  endtask

  int base_rd, base_rx, bad;

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_rd", 32'(fifo_rd), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    chk("rst_count", 32'(tokens_read), 32'd0);
    reset = 1'b0;

    // 1: reset while a token is held
    push_main(16'hBEEF);
    for (int i = 0; i < 10 && !out_valid; i++) @(negedge clk);
    chk("t1_hold_valid", 32'(out_valid), 32'd1);
    chk("t1_hold_data", 32'(out_data), 32'hBEEF);
    reset = 1'b1;
    @(negedge clk);
    chk("t1_rst_valid", 32'(out_valid), 32'd0);
    chk("t1_rst_data", 32'(out_data), 32'd0);
    chk("t1_rst_count", 32'(tokens_read), 32'd0);
    chk("t1_rst_rd", 32'(fifo_rd), 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("t1_idle_rd", 32'(fifo_rd), 32'd0);
    chk("t1_idle_valid", 32'(out_valid), 32'd0);

    // 2: single token, exact timing
    out_ready = 1'b1;
    base_rd = rd_cnt;
    base_rx = rx_cnt;
    push_main(16'h1234);
    @(negedge clk);
    chk("t2_rd_pulse", 32'(fifo_rd), 32'd1);
    @(negedge clk);
    chk("t2_rd_drop", 32'(fifo_rd), 32'd0);
    chk("t2_wait_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    chk("t2_valid", 32'(out_valid), 32'd1);
    chk("t2_data", 32'(out_data), 32'h1234);
    @(negedge clk);
    chk("t2_valid_drop", 32'(out_valid), 32'd0);
    chk("t2_rd_count", 32'(rd_cnt - base_rd), 32'd1);
    chk("t2_rx_data", 32'(rx[base_rx]), 32'h1234);
    chk("t2_tokens", 32'(tokens_read), CNT_EN ? 32'd1 : 32'd0);

    // 3: back-pressure
    out_ready = 1'b0;
    base_rd = rd_cnt;
    base_rx = rx_cnt;
    push_main(16'h0001);
    push_main(16'h0002);
    push_main(16'h0003);
    repeat (10) @(negedge clk);
    chk("t3_stall_rd", 32'(rd_cnt - base_rd), 32'd1);
    chk("t3_stall_valid", 32'(out_valid), 32'd1);
    chk("t3_stall_data", 32'(out_data), 32'h0001);
    out_ready = 1'b1;
    for (int i = 0; i < 30 && !(rx_cnt == base_rx + 3 && !out_valid); i++) @(negedge clk);
    chk("t3_rx_count", 32'(rx_cnt - base_rx), 32'd3);
    chk("t3_rx0", 32'(rx[base_rx]), 32'h0001);
    chk("t3_rx1", 32'(rx[base_rx + 1]), 32'h0002);
    chk("t3_rx2", 32'(rx[base_rx + 2]), 32'h0003);
    chk("t3_rd_total", 32'(rd_cnt - base_rd), 32'd3);
    chk("t3_tokens", 32'(tokens_read), CNT_EN ? 32'd4 : 32'd0);

    // 4: streaming with out_ready held high
    base_rd = rd_cnt;
    base_rx = rx_cnt;
    for (int k = 0; k < 8; k++) push_main(16'h0010 + 16'(k));
    for (int i = 0; i < 60 && !(rx_cnt == base_rx + 8 && !out_valid); i++) @(negedge clk);
    chk("t4_rx_count", 32'(rx_cnt - base_rx), 32'd8);
    bad = 0;
    for (int k = 0; k < 8; k++) if (rx[base_rx + k] != 16'h0010 + 16'(k)) bad++;
    chk("t4_order_errs", 32'(bad), 32'd0);
    bad = 0;
    for (int k = 1; k < 8; k++) if (rd_cyc[base_rd + k] - rd_cyc[base_rd + k - 1] != 3) bad++;
    chk("t4_spacing_errs", 32'(bad), 32'd0);
    chk("t4_rd_total", 32'(rd_cnt - base_rd), 32'd8);
    chk("t4_tokens", 32'(tokens_read), CNT_EN ? 32'd12 : 32'd0);
    repeat (2) @(negedge clk);
    chk("t4_idle_rd", 32'(fifo_rd), 32'd0);
    chk("t4_idle_valid", 32'(out_valid), 32'd0);

    // 5: RD_LATENCY=3, garbage around the one valid data cycle
    fifo_data3  = 16'h5A5A;
    fifo_empty3 = 1'b0;
    @(negedge clk);
    chk("t5_rd_pulse", 32'(fifo_rd3), 32'd1);
    fifo_empty3 = 1'b1;
    @(negedge clk);
    fifo_data3 = 16'hFFFF;
    chk("t5_w1_valid", 32'(out_valid3), 32'd0);
    @(negedge clk);
    fifo_data3 = 16'h0F0F;
    chk("t5_w2_valid", 32'(out_valid3), 32'd0);
    @(negedge clk);
    fifo_data3 = 16'hA5A5;
    chk("t5_w3_valid", 32'(out_valid3), 32'd0);
    @(negedge clk);
    fifo_data3 = 16'h1111;
    chk("t5_valid", 32'(out_valid3), 32'd1);
    chk("t5_data", 32'(out_data3), 32'hA5A5);
    @(negedge clk);
    chk("t5_valid_drop", 32'(out_valid3), 32'd0);
    chk("t5_rd_total", 32'(rd3_cnt), 32'd1);

    // 6: 17 tokens through a 4-bit counter
    for (int k = 0; k < 17; k++) push4(16'h0100 + 16'(k));
    for (int i = 0; i < 100 && !(rx4_cnt == 17 && !out_valid4); i++) @(negedge clk);
    chk("t6_rx_count", 32'(rx4_cnt), 32'd17);
    bad = 0;
    for (int k = 0; k < 17; k++) if (rx4[k] != 16'h0100 + 16'(k)) bad++;
    chk("t6_order_errs", 32'(bad), 32'd0);
    chk("t6_tokens", 32'(tokens_read4), CNT_EN ? 32'd1 : 32'd0);
    chk("t6_count_track_errs", 32'(tr_bad4), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
